// File: rtl/image_stream_reader.sv
// Streams a stored image frame out of word-addressed memory one pixel at a time, with SOF/EOL/EOF flags.
// Optional READER_GRAY_EN adds a registered luma output (gray_out) alongside each pixel.
module image_stream_reader #(
    parameter int unsigned WIDTH     = 768,
    parameter int unsigned HEIGHT    = 512,
    parameter int unsigned CH        = 3,
    parameter int unsigned DW        = 8,
    parameter int unsigned BOTTOM_UP = 1,
    parameter int unsigned AW        = 24
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_addr,
    input  logic [DW-1:0]    mem_rdata,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic [CH*DW-1:0] pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_eof,
    output logic             busy,
    output logic             done
`ifdef READER_GRAY_EN
    ,
    output logic [DW-1:0]    gray_out
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned KW = 3;
    localparam int unsigned PW = CH * DW;

    typedef enum logic [2:0] {IDLE, FETCH, CAPT, OUT, DONE} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [KW-1:0]   ch_q, ch_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   data_q, data_d;
    logic            valid_q, valid_d;
    logic            sof_q, sof_d;
    logic            eol_q, eol_d;
    logic            eof_q, eof_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            last_col_c, last_row_c;
    logic [AW-1:0]   row_sel_c, addr_c;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ch_q    <= '0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ch_q    <= ch_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        ch_d       = ch_q;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        last_col_c = (col_q == CW'(WIDTH - 1));
        last_row_c = (row_q == RW'(HEIGHT - 1));

        // Read data lands one cycle after its strobe, so slot ch-1 fills while ch is being read.
        for (int unsigned c = 0; c < CH; c++) begin
            if ((state_q == FETCH || state_q == CAPT) && ch_q == KW'(c + 1))
                data_d[c*DW +: DW] = mem_rdata;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    ch_d    = '0;
                    rd_en_d = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ch_d = ch_q + KW'(1);
                if (ch_q == KW'(CH - 1)) state_d = CAPT;
                else                     rd_en_d = 1'b1;
            end
            CAPT: begin
                ch_d    = '0;
                valid_d = 1'b1;
                sof_d   = (row_q == '0) && (col_q == '0);
                eol_d   = last_col_c;
                eof_d   = last_col_c && last_row_c;
                state_d = OUT;
            end
            OUT: begin
                if (pix_ready) begin
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eol_d   = 1'b0;
                    eof_d   = 1'b0;
                    if (last_col_c && last_row_c) begin
                        state_d = DONE;
                    end else begin
                        if (last_col_c) begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end else begin
                            col_d = col_q + CW'(1);
                        end
                        rd_en_d = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        // Address of the word to be strobed next cycle, from the updated row/col/ch.
        row_sel_c = (BOTTOM_UP != 0) ? (AW'(HEIGHT - 1) - AW'(row_d)) : AW'(row_d);
        addr_c    = AW'(WIDTH * CH) * row_sel_c + AW'(CH) * AW'(col_d) + AW'(ch_d);
        if (rd_en_d) addr_d = addr_c;
    end

    assign mem_rd_en = rd_en_q;
    assign mem_addr  = addr_q;
    assign pix_valid = valid_q;
    assign pix_data  = data_q;
    assign pix_sof   = sof_q;
    assign pix_eol   = eol_q;
    assign pix_eof   = eof_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef READER_GRAY_EN
    // Missing channels fall back to channel 0 for narrow pixels.
    localparam int unsigned C1 = (CH > 1) ? 1 : 0;
    localparam int unsigned C2 = (CH > 2) ? 2 : 0;
    localparam int unsigned GW = DW + 9;

    logic [DW-1:0] gray_q, gray_d;
    logic [GW-1:0] gray_sum_c;

    always_comb begin
        gray_sum_c = GW'(77)  * GW'(data_d[0*DW +: DW])
                   + GW'(150) * GW'(data_d[C1*DW +: DW])
                   + GW'(29)  * GW'(data_d[C2*DW +: DW]);
        gray_d = gray_q;
        if (state_q == CAPT) gray_d = DW'(gray_sum_c >> 8);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) gray_q <= '0;
        else          gray_q <= gray_d;
    end

    assign gray_out = gray_q;
`endif

endmodule
